stub_link_framer: RTL and testbench
===================================

Name: stub_link_framer

Overview:
- Sits directly downstream of the priority-encoded memory readout stage; consumes its merged 54-bit stub stream and per-word valid bit.
- Buffers the stream in a small FIFO and frames each bunch crossing (BX) as header, data words, trailer.
- Frames drive a 64-bit valid/ready link interface towards the transceiver/serializer.

Parameters:
- DEPTH, 16, FIFO depth in words (power of two, 4..64).
- SETUP_CYC, 3, cycles after start_evt during which `none` is ignored (covers upstream setup holdoff).
- CNT_W, 10, width of the per-event data word counter.

Ports:
- clk  in  1  processing clock
- reset  in  1  asynchronous, active-low reset
- start_evt  in  1  one-cycle pulse marking a new event; same pulse that restarts the upstream readout
- BX  in  3  bunch crossing number, sampled on start_evt
- mem_dat_stream  in  54  merged stub data from the readout stage
- valid  in  1  mem_dat_stream holds a valid word this cycle
- none  in  1  upstream has no more data for the current event
- link_data  out  64  framed output word
- link_valid  out  1  link_data valid
- link_ready  in  1  downstream accepts link_data when link_valid & link_ready
- overflow  out  1  sticky; at least one input word dropped since reset
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset low, async): state=IDLE, FIFO empty, counters 0, link_valid=0, link_data=0, overflow=0, busy=0.
- Word formats, type in [63:62]:
  - Header: {2'b10, 3'b0, BX[2:0], 56'h0}.
  - Data: {2'b01, 8'h00, stub[53:0]}.
  - Trailer: {2'b11, 3'b0, BX[2:0], 44'h0, trunc, ovf, count[CNT_W-1:0]}.
  - Trailer fields are zero-extended to fill 64 bits.
- Input side:
  - On every cycle with valid=1 and FIFO not full, write mem_dat_stream.
  - If the FIFO is full, drop the word and set both the event ovf flag and the sticky overflow output.
  - Writes are accepted only in states HDR and DATA; valid in IDLE or TRL is ignored.
- FSM states:
  - IDLE: on start_evt, latch BX, clear count/ovf/trunc, load the setup counter with SETUP_CYC, go to HDR.
  - HDR: present the header (link_valid=1). On handshake, go to DATA.
  - DATA: while the FIFO is non-empty, present the FIFO head. On handshake, pop and increment count (saturates at all-ones). When the setup counter has expired, none=1, FIFO empty and no write this cycle, go to TRL.
  - TRL: present the trailer. On handshake, go to IDLE.
- Output stability: link_data and link_valid are registered. While link_valid=1 and link_ready=0, link_data is held stable.
- Latency: a word written in cycle N can appear on link_data in cycle N+1 at the earliest, if the header has already been accepted and the FIFO was empty.
- start_evt in HDR or DATA (event not yet closed):
  - Set trunc, flush the FIFO, and finish the current header if it is pending.
  - Then emit the trailer for the old event with the old BX, and latch the new BX into a pending register.
  - After the trailer handshake, go directly to HDR for the new event (not IDLE).
- start_evt in TRL: latch the pending BX. After the trailer handshake, go to HDR.
- start_evt in IDLE coinciding with valid: valid is ignored (upstream holds off output during setup).
- A simultaneous FIFO push and pop is allowed; occupancy is unchanged.
- count counts data words emitted, not dropped words.

Decomposition:
- Shared package (tracklet link pkg):
  - word-type codes HDR=2'b10, DAT=2'b01, TRL=2'b11
  - field offsets and widths
  - FSM state enum {IDLE, HDR, DATA, TRL}
- One natural sub-module, sync_fifo:
  - parameterised width/depth, first-word-fall-through
  - ports: full, empty, flush
  - asynchronous active-low reset

Test Plan:
- Basic frame: reset release; start_evt with BX=3'd5; 3 valid words 0x1,0x2,0x3 one cycle apart; none after; link_ready=1 → link emits header 0x8500_0000_0000_0000, then data 0x4000_0000_0000_0001..3, then trailer with BX=5, count=3, ovf=0, trunc=0.
- Empty event: start_evt with BX=1; none=1 throughout → header, then trailer with count=0, emitted no earlier than SETUP_CYC cycles after start_evt.
- Backpressure: link_ready low for 5 cycles during DATA with 4 words pending → link_data held constant while stalled; no loss or reorder; trailer count=4.
- Overflow: DEPTH=16, link_ready=0, 20 consecutive valid words → 16 data words then trailer with count=16, ovf=1; sticky overflow=1 until reset.
- Truncation: start_evt (BX=2), 2 words, second start_evt (BX=3) before none → trailer shows BX=2, trunc=1; next header shows BX=3.
- Async reset mid-DATA: reset low between clock edges → link_valid=0, busy=0 immediately; FIFO empty after release.

Source files
------------

// File: rtl/stub_link_framer_pkg.sv
// Shared definitions for the stub link framer: word-type codes, field layout,
// FSM states and word builders.
package stub_link_framer_pkg;

    localparam int LINK_W   = 64;
    localparam int STUB_W   = 54;
    localparam int BX_W     = 3;
    localparam int TYPE_LSB = 62;
    localparam int BX_LSB   = 56;

    localparam logic [1:0] TYPE_HDR = 2'b10;
    localparam logic [1:0] TYPE_DAT = 2'b01;
    localparam logic [1:0] TYPE_TRL = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        TRL
    } state_t;

    function automatic logic [LINK_W-1:0] make_hdr(input logic [BX_W-1:0] bx);
        logic [LINK_W-1:0] w;
        w = '0;
        w[TYPE_LSB +: 2] = TYPE_HDR;
        w[BX_LSB +: BX_W] = bx;
        return w;
    endfunction

    function automatic logic [LINK_W-1:0] make_dat(input logic [STUB_W-1:0] stub);
        logic [LINK_W-1:0] w;
        w = '0;
        w[TYPE_LSB +: 2] = TYPE_DAT;
        w[STUB_W-1:0] = stub;
        return w;
    endfunction

endpackage

// File: rtl/stub_link_framer_sync_fifo.sv
// First-word-fall-through FIFO: the head word is visible on rd_data whenever
// empty is low. Flush discards the whole content in one cycle.
module stub_link_framer_sync_fifo #(
    parameter int WIDTH = 54,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             push;
    logic             pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign push    = wr_en && !full && !flush;
    assign pop     = rd_en && !empty && !flush;
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/stub_link_framer.sv
// Frames the merged stub stream of each bunch crossing as header, data words
// and trailer onto a registered 64-bit valid/ready link.
module stub_link_framer
    import stub_link_framer_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int SETUP_CYC = 3,
    parameter int CNT_W     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_evt,
    input  logic [BX_W-1:0]   BX,
    input  logic [STUB_W-1:0] mem_dat_stream,
    input  logic              valid,
    input  logic              none,
    output logic [LINK_W-1:0] link_data,
    output logic              link_valid,
    input  logic              link_ready,
    output logic              overflow,
    output logic              busy
);
    localparam int SETUP_W = (SETUP_CYC < 1) ? 1 : $clog2(SETUP_CYC + 1);

    state_t              state_reg, state_next;
    logic [BX_W-1:0]     bx_reg, bx_next;
    logic [BX_W-1:0]     pend_bx_reg, pend_bx_next;
    logic                pend_reg, pend_next;
    logic                close_reg, close_next;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic                ovf_reg, ovf_next;
    logic                trunc_reg, trunc_next;
    logic                overflow_reg, overflow_next;
    logic [SETUP_W-1:0]  setup_cnt_reg, setup_next;
    logic                link_valid_reg, link_valid_next;
    logic [LINK_W-1:0]   link_data_reg, link_data_next;

    logic [STUB_W-1:0]   fifo_rd_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_flush;

    logic                slot_free;
    logic                handshake;
    logic                wr_window;
    logic                bypass;
    logic                new_evt;
    logic [BX_W-1:0]     new_bx;
    logic [CNT_W-1:0]    count_inc;
    logic [LINK_W-1:0]   trl_word;

    stub_link_framer_sync_fifo #(
        .WIDTH (STUB_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (fifo_flush),
        .wr_en   (fifo_push),
        .wr_data (mem_dat_stream),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The output register may be reloaded when empty or being consumed.
    assign slot_free = !link_valid_reg || link_ready;
    assign handshake = link_valid_reg && link_ready;
    assign wr_window = ((state_reg == HDR) || (state_reg == DATA)) && !close_reg && !start_evt;
    assign count_inc = (&count_reg) ? count_reg : count_reg + CNT_W'(1);

    always_comb begin
        trl_word = '0;
        trl_word[TYPE_LSB +: 2]   = TYPE_TRL;
        trl_word[BX_LSB +: BX_W]  = bx_reg;
        trl_word[CNT_W+1]         = trunc_reg;
        trl_word[CNT_W]           = ovf_reg;
        trl_word[CNT_W-1:0]       = count_reg;
    end

    always_comb begin
        state_next      = state_reg;
        bx_next         = bx_reg;
        pend_bx_next    = pend_bx_reg;
        pend_next       = pend_reg;
        close_next      = close_reg;
        count_next      = count_reg;
        ovf_next        = ovf_reg;
        trunc_next      = trunc_reg;
        overflow_next   = overflow_reg;
        setup_next      = (setup_cnt_reg != '0) ? setup_cnt_reg - SETUP_W'(1) : setup_cnt_reg;
        link_valid_next = link_valid_reg;
        link_data_next  = link_data_reg;
        fifo_push       = 1'b0;
        fifo_pop        = 1'b0;
        fifo_flush      = 1'b0;
        bypass          = 1'b0;
        new_evt         = 1'b0;
        new_bx          = BX;

        if (start_evt) begin
            setup_next = SETUP_W'(SETUP_CYC);
        end

        // A new event arriving before the old one closed truncates it; the
        // trailer is sent once the output register is free.
        if (start_evt && ((state_reg == HDR) || (state_reg == DATA))) begin
            trunc_next   = 1'b1;
            close_next   = 1'b1;
            pend_next    = 1'b1;
            pend_bx_next = BX;
            fifo_flush   = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (start_evt) begin
                    new_evt = 1'b1;
                end
            end
            HDR: begin
                if (handshake) begin
                    link_valid_next = 1'b0;
                    state_next      = DATA;
                end
            end
            DATA: begin
                if (start_evt) begin
                    if (slot_free) begin
                        link_valid_next = 1'b0;
                    end
                end else if (!slot_free) begin
                    link_valid_next = link_valid_reg;
                end else if (close_reg) begin
                    link_valid_next = 1'b1;
                    link_data_next  = trl_word;
                    state_next      = TRL;
                end else if (!fifo_empty) begin
                    link_valid_next = 1'b1;
                    link_data_next  = make_dat(fifo_rd_data);
                    fifo_pop        = 1'b1;
                    count_next      = count_inc;
                end else if (valid) begin
                    // Empty FIFO: forward the incoming word straight to the link.
                    bypass          = 1'b1;
                    link_valid_next = 1'b1;
                    link_data_next  = make_dat(mem_dat_stream);
                    count_next      = count_inc;
                end else if ((setup_cnt_reg == '0) && none) begin
                    link_valid_next = 1'b1;
                    link_data_next  = trl_word;
                    state_next      = TRL;
                end else begin
                    link_valid_next = 1'b0;
                end
            end
            TRL: begin
                if (handshake) begin
                    if (pend_reg || start_evt) begin
                        new_evt = 1'b1;
                        new_bx  = start_evt ? BX : pend_bx_reg;
                    end else begin
                        link_valid_next = 1'b0;
                        state_next      = IDLE;
                    end
                end else if (start_evt) begin
                    pend_next    = 1'b1;
                    pend_bx_next = BX;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (new_evt) begin
            bx_next         = new_bx;
            count_next      = '0;
            ovf_next        = 1'b0;
            trunc_next      = 1'b0;
            close_next      = 1'b0;
            pend_next       = 1'b0;
            link_valid_next = 1'b1;
            link_data_next  = make_hdr(new_bx);
            state_next      = HDR;
        end

        if (wr_window && valid && !bypass) begin
            if (!fifo_full) begin
                fifo_push = 1'b1;
            end else begin
                ovf_next      = 1'b1;
                overflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            bx_reg         <= '0;
            pend_bx_reg    <= '0;
            pend_reg       <= 1'b0;
            close_reg      <= 1'b0;
            count_reg      <= '0;
            ovf_reg        <= 1'b0;
            trunc_reg      <= 1'b0;
            overflow_reg   <= 1'b0;
            setup_cnt_reg  <= '0;
            link_valid_reg <= 1'b0;
            link_data_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            bx_reg         <= bx_next;
            pend_bx_reg    <= pend_bx_next;
            pend_reg       <= pend_next;
            close_reg      <= close_next;
            count_reg      <= count_next;
            ovf_reg        <= ovf_next;
            trunc_reg      <= trunc_next;
            overflow_reg   <= overflow_next;
            setup_cnt_reg  <= setup_next;
            link_valid_reg <= link_valid_next;
            link_data_reg  <= link_data_next;
        end
    end

    assign link_data  = link_data_reg;
    assign link_valid = link_valid_reg;
    assign overflow   = overflow_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_stub_link_framer.sv
// Scoreboard bench for stub_link_framer: table-driven events plus hand-written
// backpressure, overflow, truncation and asynchronous reset sequences.
module tb_stub_link_framer;
    localparam int DEPTH     = 16;
    localparam int SETUP_CYC = 3;
    localparam int CNT_W     = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_evt = 1'b0;
    logic [2:0]  BX = 3'd0;
    logic [53:0] mem_dat_stream = '0;
    logic        valid = 1'b0;
    logic        none = 1'b0;
    logic        link_ready = 1'b0;
    logic [63:0] link_data;
    logic        link_valid;
    logic        overflow;
    logic        busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ready_mode = 0;
    int last_trl_cyc = 0;
    int evt_start_cyc = 0;
    logic        stall_prev = 1'b0;
    logic [63:0] stall_data = '0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [2:0]  bx;
        int          n;
        int          gap;
        logic [53:0] base;
        int          rmode;
        logic [9:0]  exp_cnt;
    } vec_t;
    vec_t vecs[5];

    stub_link_framer #(.DEPTH(DEPTH), .SETUP_CYC(SETUP_CYC), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .start_evt      (start_evt),
        .BX             (BX),
        .mem_dat_stream (mem_dat_stream),
        .valid          (valid),
        .none           (none),
        .link_data      (link_data),
        .link_valid     (link_valid),
        .link_ready     (link_ready),
        .overflow       (overflow),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] hdr_w(input logic [2:0] bx);
        return {2'b10, 3'b000, bx, 56'h0};
    endfunction

    function automatic logic [63:0] dat_w(input logic [53:0] s);
        return {2'b01, 8'h00, s};
    endfunction

    function automatic logic [63:0] trl_w(input logic [2:0] bx, input logic trunc,
                                          input logic ovf, input logic [9:0] cnt);
        return {2'b11, 3'b000, bx, 44'h0, trunc, ovf, cnt};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 500) begin
            tick();
            k++;
        end
        check(name, 64'(busy), 64'd0);
        check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic start(input logic [2:0] bx);
        start_evt = 1'b1;
        BX = bx;
        evt_start_cyc = cyc;
        tick();
        start_evt = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (ready_mode == 0) link_ready = 1'b1;
        else if (ready_mode == 1) link_ready = 1'($urandom_range(0, 1));
    end

    // Link monitor: pops the scoreboard on each handshake and checks that a
    // stalled word stays put.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            if (stall_prev) begin
                check("hold_valid", 64'(link_valid), 64'd1);
                check("hold_data", link_data, stall_data);
            end
            stall_prev = link_valid && !link_ready;
            stall_data = link_data;
            if (link_valid && link_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %h required none", link_data);
                end else begin
                    check("word", link_data, exp_q.pop_front());
                end
                if (link_data[63:62] == 2'b11) last_trl_cyc = cyc;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'd5, 3, 0, 54'h1, 0, 10'd3};
        vecs[1] = '{3'd1, 0, 0, 54'h0, 0, 10'd0};
        vecs[2] = '{3'd7, 8, 1, 54'h3F_FFFF_FFFF_FF00, 1, 10'd8};
        vecs[3] = '{3'd0, 6, 0, 54'h2A_AAAA_5555_0000, 1, 10'd6};
        vecs[4] = '{3'd6, 2, 3, 54'h15_0F0F_0F0F_0F0F, 0, 10'd2};

        repeat (3) tick();
        check("rst_link_valid", 64'(link_valid), 64'd0);
        check("rst_link_data", link_data, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        reset = 1'b1;
        repeat (2) tick();

        for (int v = 0; v < 5; v++) begin
            ready_mode = vecs[v].rmode;
            link_ready = 1'b1;
            none = 1'b0;
            exp_q.push_back(hdr_w(vecs[v].bx));
            start(vecs[v].bx);
            for (int i = 0; i < vecs[v].n; i++) begin
                valid = 1'b1;
                mem_dat_stream = vecs[v].base + 54'(i);
                exp_q.push_back(dat_w(vecs[v].base + 54'(i)));
                tick();
                valid = 1'b0;
                for (int g = 0; g < vecs[v].gap; g++) tick();
            end
            none = 1'b1;
            exp_q.push_back(trl_w(vecs[v].bx, 1'b0, 1'b0, vecs[v].exp_cnt));
            wait_idle("evt_idle");
            if (vecs[v].n == 0)
                check("empty_timing", 64'((last_trl_cyc - evt_start_cyc) > SETUP_CYC), 64'd1);
            $display("event bx=%0d words=%0d done, total=%0d", vecs[v].bx, vecs[v].n, total);
        end

        // Backpressure: four words queued while the link stalls five cycles.
        ready_mode = 2;
        link_ready = 1'b1;
        none = 1'b0;
        exp_q.push_back(hdr_w(3'd4));
        start(3'd4);
        tick();
        link_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1;
            mem_dat_stream = 54'h100 + 54'(i);
            exp_q.push_back(dat_w(54'h100 + 54'(i)));
            tick();
        end
        valid = 1'b0;
        tick();
        link_ready = 1'b1;
        none = 1'b1;
        exp_q.push_back(trl_w(3'd4, 1'b0, 1'b0, 10'd4));
        wait_idle("bp_idle");
        $display("backpressure sequence done, total=%0d", total);

        // Overflow: header stalled, 20 words offered into a 16-deep FIFO.
        link_ready = 1'b0;
        none = 1'b0;
        exp_q.push_back(hdr_w(3'd3));
        start(3'd3);
        for (int i = 0; i < 20; i++) begin
            valid = 1'b1;
            mem_dat_stream = 54'h2000 + 54'(i);
            if (i < DEPTH) exp_q.push_back(dat_w(54'h2000 + 54'(i)));
            tick();
        end
        valid = 1'b0;
        check("overflow_set", 64'(overflow), 64'd1);
        link_ready = 1'b1;
        none = 1'b1;
        exp_q.push_back(trl_w(3'd3, 1'b0, 1'b1, 10'd16));
        wait_idle("ovf_idle");
        check("overflow_sticky", 64'(overflow), 64'd1);
        $display("overflow sequence done, total=%0d", total);

        // Truncation with queued words flushed while the header is stalled.
        link_ready = 1'b0;
        none = 1'b0;
        exp_q.push_back(hdr_w(3'd2));
        start(3'd2);
        for (int i = 0; i < 2; i++) begin
            valid = 1'b1;
            mem_dat_stream = 54'h300 + 54'(i);
            tick();
        end
        valid = 1'b0;
        exp_q.push_back(trl_w(3'd2, 1'b1, 1'b0, 10'd0));
        exp_q.push_back(hdr_w(3'd3));
        start(3'd3);
        tick();
        link_ready = 1'b1;
        repeat (3) tick();
        none = 1'b1;
        exp_q.push_back(trl_w(3'd3, 1'b0, 1'b0, 10'd0));
        wait_idle("trunc_flush_idle");
        $display("truncation (flushed) sequence done, total=%0d", total);

        // Truncation after both words were emitted.
        ready_mode = 0;
        link_ready = 1'b1;
        none = 1'b0;
        exp_q.push_back(hdr_w(3'd2));
        start(3'd2);
        for (int i = 0; i < 2; i++) begin
            valid = 1'b1;
            mem_dat_stream = 54'h400 + 54'(i);
            exp_q.push_back(dat_w(54'h400 + 54'(i)));
            tick();
        end
        valid = 1'b0;
        repeat (4) tick();
        exp_q.push_back(trl_w(3'd2, 1'b1, 1'b0, 10'd2));
        exp_q.push_back(hdr_w(3'd3));
        start(3'd3);
        repeat (3) tick();
        none = 1'b1;
        exp_q.push_back(trl_w(3'd3, 1'b0, 1'b0, 10'd0));
        wait_idle("trunc_idle");
        check("overflow_still_sticky", 64'(overflow), 64'd1);
        $display("truncation (drained) sequence done, total=%0d", total);

        // Asynchronous reset while data is stalled on the link.
        ready_mode = 2;
        link_ready = 1'b1;
        none = 1'b0;
        exp_q.push_back(hdr_w(3'd6));
        start(3'd6);
        tick();
        link_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1;
            mem_dat_stream = 54'h500 + 54'(i);
            tick();
        end
        valid = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_link_valid", 64'(link_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_link_data", link_data, 64'd0);
        check("arst_overflow", 64'(overflow), 64'd0);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b1;
        link_ready = 1'b1;
        repeat (3) tick();
        check("post_rst_link_valid", 64'(link_valid), 64'd0);
        none = 1'b1;
        exp_q.push_back(hdr_w(3'd5));
        start(3'd5);
        exp_q.push_back(trl_w(3'd5, 1'b0, 1'b0, 10'd0));
        wait_idle("post_rst_idle");
        $display("async reset sequence done, total=%0d", total);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
